// File: rtl/tt_and_gate_example.sv
// Masked-AND datapath with a saturating popcount accumulator.
// It has a loadable weight mask and registered status bits on the bidirectional byte.
module tt_and_gate_example (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0]  WEIGHT_RST = 8'hFF;
  localparam logic [9:0]  ACC_MAX    = 10'd1023;

  logic       load_w;
  logic       accum;
  logic       clear;
  logic       out_sel;
  logic       unused_uio_hi;

  logic [7:0] weight_q, weight_d;
  logic [7:0] and_q,    and_d;
  logic [9:0] acc_q,    acc_d;
  logic       valid_q,  valid_d;
  logic       ovf_q,    ovf_d;

  logic [7:0]  masked;
  logic [3:0]  masked_ones;
  logic [10:0] acc_sum;

  assign load_w        = uio_in[0];
  assign accum         = uio_in[1];
  assign clear         = uio_in[2];
  assign out_sel       = uio_in[3];
  assign unused_uio_hi = &{1'b0, uio_in[7:4]};

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  assign masked      = ui_in & weight_q;
  assign masked_ones = popcount8(masked);
  // One spare bit so an overflowing add is visible before it saturates.
  assign acc_sum     = {1'b0, acc_q} + {7'b0, masked_ones};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    weight_d = weight_q;
    and_d    = and_q;
    acc_d    = acc_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;

    if (ena) begin
      and_d = masked;
      if (clear) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        valid_d = 1'b0;
      end else if (load_w) begin
        weight_d = ui_in;
        valid_d  = 1'b0;
      end else if (accum) begin
        valid_d = 1'b1;
        if (acc_sum > {1'b0, ACC_MAX}) begin
          acc_d = ACC_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = acc_sum[9:0];
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // The harness names this reset rst_n, but it is active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      weight_q <= WEIGHT_RST;
      and_q    <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the values
      // from before the edge, whatever the statement order.
      weight_q <= weight_d;
      and_q    <= and_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign uo_out  = out_sel ? acc_q[7:0] : and_q;
  assign uio_out = {ovf_q, valid_q, acc_q[9:8], 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_and_gate_example.sv
// Directed bench for tt_and_gate_example.
// Each step queues its expected outputs, then compares them after the edge.
module tb_tt_and_gate_example;

  localparam logic [7:0] C_LOAD = 8'h01;
  localparam logic [7:0] C_ACC  = 8'h02;
  localparam logic [7:0] C_CLR  = 8'h04;
  localparam logic [7:0] C_SEL  = 8'h08;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string      tag;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  tt_and_gate_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] uo, input logic [7:0] uio);
    exp_t e;
    e.tag = tag;
    e.uo  = uo;
    e.uio = uio;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".uo_out"},  uo_out,  e.uo);
      check({e.tag, ".uio_out"}, uio_out, e.uio);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] ui, input logic [7:0] ctl);
    @(negedge clk);
    ena    = en;
    ui_in  = ui;
    uio_in = ctl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] raw;
    logic [9:0]  acc_e;
    logic        ovf_e;

    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'hA5;
    uio_in = 8'h00;

    // Reset state, checked mid-cycle and for both out_sel values.
    #12;
    push("rst_sel0", 8'h00, 8'h00);
    drain();
    uio_in = C_SEL;
    #1;
    push("rst_sel1", 8'h00, 8'h00);
    drain();
    check("rst_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n  = 1'b0;
    uio_in = 8'h00;

    // The reset weight is all ones, so and_q follows ui_in.
    push("r26", 8'hA5, 8'h00);
    step(1'b1, 8'hA5, 8'h00);
    drain();
    check("r26_oe", uio_oe, 8'hF0);

    // Load a weight, then AND with it.
    push("r27_load", 8'h0F, 8'h00);
    step(1'b1, 8'h0F, C_LOAD);
    drain();
    push("r27_and", 8'h0C, 8'h00);
    step(1'b1, 8'h3C, 8'h00);
    drain();

    // Pulse reset to restore the weight, then run three accumulate edges.
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("r28_acc%0d", k), 8'hFF, 8'h40);
      step(1'b1, 8'hFF, C_ACC);
      drain();
    end
    push("r28_idle", 8'hFF, 8'h00);
    step(1'b1, 8'hFF, 8'h00);
    drain();
    uio_in = C_SEL;
    #1;
    push("r28_sel", 8'h18, 8'h00);
    drain();

    // Build acc=5, then assert all three commands together.
    push("r30_clr", 8'h00, 8'h00);
    step(1'b1, 8'h00, C_CLR);
    drain();
    push("r30_load", 8'h1F, 8'h00);
    step(1'b1, 8'h1F, C_LOAD);
    drain();
    push("r30_acc", 8'h1F, 8'h40);
    step(1'b1, 8'h1F, C_ACC);
    drain();
    uio_in = C_SEL;
    #1;
    push("r30_acc5", 8'h05, 8'h40);
    drain();
    push("r30_all", 8'h00, 8'h00);
    step(1'b1, 8'h00, C_LOAD | C_ACC | C_CLR | C_SEL);
    drain();
    push("r30_wkeep", 8'h1F, 8'h00);
    step(1'b1, 8'hFF, 8'h00);
    drain();

    // With ena low, every register holds.
    push("r31_pre", 8'h05, 8'h40);
    step(1'b1, 8'hFF, C_ACC | C_SEL);
    drain();
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("r31_hold%0d", k), 8'h05, 8'h40);
      step(1'b0, 8'hFF, C_ACC | C_SEL);
      drain();
    end
    uio_in = C_ACC;
    #1;
    push("r31_andq", 8'h1F, 8'h40);
    drain();

    // Accumulate until saturation, then clear.
    push("r29_load", 8'h1F, 8'h00);
    step(1'b1, 8'hFF, C_LOAD);
    drain();
    push("r29_clr", 8'h00, 8'h00);
    step(1'b1, 8'h00, C_CLR);
    drain();
    for (int k = 1; k <= 129; k++) begin
      raw   = 11'(8 * k);
      ovf_e = (raw > 11'd1023);
      acc_e = ovf_e ? 10'd1023 : raw[9:0];
      push($sformatf("r29_acc%0d", k), acc_e[7:0], {ovf_e, 1'b1, acc_e[9:8], 4'b0000});
      step(1'b1, 8'hFF, C_ACC | C_SEL);
      drain();
    end
    push("r29_clear", 8'h00, 8'h00);
    step(1'b1, 8'h00, C_CLR | C_SEL);
    drain();

    // Asynchronous reset in the middle of a cycle.
    push("r32_pre", 8'h08, 8'h40);
    step(1'b1, 8'hFF, C_ACC | C_SEL);
    drain();
    #3;
    rst_n = 1'b1;
    #1;
    push("r32_sel1", 8'h00, 8'h00);
    drain();
    uio_in = 8'h00;
    #1;
    push("r32_sel0", 8'h00, 8'h00);
    drain();
    check("r32_oe", uio_oe, 8'hF0);
    #1;
    rst_n = 1'b0;

    // The first edge after reset starts from acc=0 with the all-ones weight.
    push("r24_first", 8'h04, 8'h40);
    step(1'b1, 8'hF0, C_ACC | C_SEL);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
